mesi_snoop_responder: RTL and testbench

//  Bus-side (responder) end of the cache's MESI protocol. Holds the MESI state of every line.

---
 rtl/mesi_snoop_responder.sv | 121 ++++++++++++
 tb/tb_mesi_snoop_responder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mesi_snoop_responder.sv
// mesi_snoop_responder: bus-side MESI snoop responder that holds line states, answers snoops and runs writebacks
// Ports:
//   clk, reset             clock; asynchronous active-high reset (all lines I, FSM IDLE)
//   snp_valid/snp_ready    snoop request handshake; snp_op (READ/RFO/INVALIDATE/WRITE), snp_idx
//   snp_rsp_valid          one-cycle response strobe with snp_result (NOHIT/HIT/HITM, held until next response)
//   wb_req/wb_idx/wb_ack   writeback handshake used before a HITM response
//   loc_valid/loc_ready    local controller state-write handshake; loc_idx, loc_state
//   rd_idx/rd_state        combinational read of committed line state
//   proto_err              one-cycle pulse alongside a response to an illegal snoop
module mesi_snoop_responder #(
  parameter int NUM_LINES = 16,
  parameter int IDX_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             snp_valid,
  output logic             snp_ready,
  input  logic [1:0]       snp_op,
  input  logic [IDX_W-1:0] snp_idx,
  output logic             snp_rsp_valid,
  output logic [1:0]       snp_result,
  output logic             wb_req,
  output logic [IDX_W-1:0] wb_idx,
  input  logic             wb_ack,
  input  logic             loc_valid,
  output logic             loc_ready,
  input  logic [IDX_W-1:0] loc_idx,
  input  logic [1:0]       loc_state,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_state,
  output logic             proto_err
);
  typedef enum logic [1:0] {IDLE, EVAL, WB, RESP} state_t;
  localparam logic [1:0] ST_I = 2'b00, ST_S = 2'b01, ST_E = 2'b10, ST_M = 2'b11;
  localparam logic [1:0] OP_READ = 2'b00, OP_INV = 2'b10, OP_WRITE = 2'b11;
  localparam logic [1:0] RES_NOHIT = 2'b00, RES_HIT = 2'b01, RES_HITM = 2'b10;
  state_t           state_q, state_d;
  logic [1:0]       lines_q [NUM_LINES];
  logic [1:0]       lines_d [NUM_LINES];
  logic [1:0]       op_q, op_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       result_q, result_d;
  logic             perr_q, perr_d;
  logic [IDX_W-1:0] wb_idx_q, wb_idx_d;
  logic             idx_ok, loc_ok, rd_ok, hit, need_wb, commit, err;
  logic [1:0]       cur, nxt, res;
  // Indices beyond NUM_LINES only exist when NUM_LINES is not a power of two; they read as I.
  assign idx_ok = int'(idx_q) < NUM_LINES;
  assign loc_ok = int'(loc_idx) < NUM_LINES;
  assign rd_ok  = int'(rd_idx) < NUM_LINES;
  assign cur    = idx_ok ? lines_q[idx_q] : ST_I;
  assign hit    = cur != ST_I;
  // READ and RFO (op[1]==0) to a Modified line must write the line back first.
  assign need_wb = cur == ST_M && !op_q[1];
  assign nxt = op_q == OP_READ ? (hit ? ST_S : ST_I) : op_q == OP_WRITE ? cur : ST_I;
  assign res = (!hit || op_q == OP_WRITE) ? RES_NOHIT : need_wb ? RES_HITM : RES_HIT;
  // Another cache invalidating our exclusive copy, or writing back a line we hold, is illegal.
  assign err = op_q == OP_INV ? (cur == ST_M || cur == ST_E) : op_q == OP_WRITE ? hit : 1'b0;
  assign commit = (state_q == EVAL && !need_wb) || (state_q == WB && wb_ack);
  always_comb begin
    state_d  = state_q;
    lines_d  = lines_q;
    op_d     = op_q;
    idx_d    = idx_q;
    result_d = result_q;
    wb_idx_d = wb_idx_q;
    perr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (snp_valid) begin
          op_d    = snp_op;
          idx_d   = snp_idx;
          state_d = EVAL;
        end else if (loc_valid && loc_ok) begin
          lines_d[loc_idx] = loc_state;
        end
      end
      EVAL: begin
        if (need_wb) begin
          state_d  = WB;
          wb_idx_d = idx_q;
        end
      end
      default: ;
    endcase
    if (commit) begin
      if (idx_ok) lines_d[idx_q] = nxt;
      result_d = res;
      perr_d   = err;
      state_d  = RESP;
    end
    if (state_q == RESP) state_d = IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      lines_q  <= '{default: ST_I};
      op_q     <= 2'b00;
      idx_q    <= '0;
      result_q <= RES_NOHIT;
      perr_q   <= 1'b0;
      wb_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      lines_q  <= lines_d;
      op_q     <= op_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      perr_q   <= perr_d;
      wb_idx_q <= wb_idx_d;
    end
  end
  assign snp_ready     = state_q == IDLE;
  assign loc_ready     = state_q == IDLE && !snp_valid;
  assign snp_rsp_valid = state_q == RESP;
  assign snp_result    = result_q;
  assign wb_req        = state_q == WB;
  assign wb_idx        = wb_idx_q;
  assign proto_err     = perr_q;
  assign rd_state      = rd_ok ? lines_q[rd_idx] : ST_I;
endmodule

// File: tb/tb_mesi_snoop_responder.sv
// tb_mesi_snoop_responder: directed self-checking bench for mesi_snoop_responder
module tb_mesi_snoop_responder;
  logic       clk = 1'b0, reset = 1'b1;
  logic       snp_valid = 1'b0, snp_ready;
  logic [1:0] snp_op = 2'b00;
  logic [3:0] snp_idx = 4'd0;
  logic       snp_rsp_valid;
  logic [1:0] snp_result;
  logic       wb_req;
  logic [3:0] wb_idx;
  logic       wb_ack = 1'b0;
  logic       loc_valid = 1'b0, loc_ready;
  logic [3:0] loc_idx = 4'd0;
  logic [1:0] loc_state = 2'b00;
  logic [3:0] rd_idx = 4'd0;
  logic [1:0] rd_state;
  logic       proto_err;
  int checks = 0, failures = 0;
  mesi_snoop_responder #(.NUM_LINES(16), .IDX_W(4)) dut (
    .clk(clk), .reset(reset),
    .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_op(snp_op), .snp_idx(snp_idx),
    .snp_rsp_valid(snp_rsp_valid), .snp_result(snp_result),
    .wb_req(wb_req), .wb_idx(wb_idx), .wb_ack(wb_ack),
    .loc_valid(loc_valid), .loc_ready(loc_ready), .loc_idx(loc_idx), .loc_state(loc_state),
    .rd_idx(rd_idx), .rd_state(rd_state), .proto_err(proto_err)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic loc_write(input logic [3:0] idx, input logic [1:0] st);
    int n = 0;
    loc_valid = 1'b1;
    loc_idx   = idx;
    loc_state = st;
    while (!loc_ready && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (!loc_ready) begin
      failures++;
      $display("FAIL loc_write_timeout idx=%0d loc_ready=%0b required=1", idx, loc_ready);
    end
    tick();
    loc_valid = 1'b0;
  endtask
  task automatic send_snoop(input logic [1:0] op, input logic [3:0] idx);
    snp_valid = 1'b1;
    snp_op    = op;
    snp_idx   = idx;
    checks++;
    if (snp_ready !== 1'b1) begin failures++; $display("FAIL snp_ready got=%b exp=1", snp_ready); end
    tick();
    snp_valid = 1'b0;
  endtask
  task automatic test_reset;
    reset = 1'b1;
    #1;
    checks++; if (snp_rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid got=%b exp=0", snp_rsp_valid); end
    checks++; if (snp_result !== 2'b00) begin failures++; $display("FAIL rst_result got=%b exp=00", snp_result); end
    checks++; if (wb_req !== 1'b0) begin failures++; $display("FAIL rst_wb_req got=%b exp=0", wb_req); end
    checks++; if (wb_idx !== 4'd0) begin failures++; $display("FAIL rst_wb_idx got=%0d exp=0", wb_idx); end
    checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL rst_proto_err got=%b exp=0", proto_err); end
    #11 reset = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i);
      #1;
      checks++; if (rd_state !== 2'b00) begin failures++; $display("FAIL rst_line%0d got=%b exp=00", i, rd_state); end
    end
  endtask
  task automatic test_read_hit;
    loc_write(4'd3, 2'b10);
    rd_idx = 4'd3;
    #1;
    checks++; if (rd_state !== 2'b10) begin failures++; $display("FAIL rh_loc_e got=%b exp=10", rd_state); end
    send_snoop(2'b00, 4'd3);
    checks++; if (snp_rsp_valid !== 1'b0) begin failures++; $display("FAIL rh_early_rsp got=%b exp=0", snp_rsp_valid); end
    checks++; if (rd_state !== 2'b10) begin failures++; $display("FAIL rh_precommit got=%b exp=10", rd_state); end
    tick();
    checks++; if (snp_rsp_valid !== 1'b1) begin failures++; $display("FAIL rh_rsp got=%b exp=1", snp_rsp_valid); end
    checks++; if (snp_result !== 2'b01) begin failures++; $display("FAIL rh_result got=%b exp=01", snp_result); end
    checks++; if (rd_state !== 2'b01) begin failures++; $display("FAIL rh_state got=%b exp=01", rd_state); end
    checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL rh_perr got=%b exp=0", proto_err); end
    tick();
    checks++; if (snp_rsp_valid !== 1'b0) begin failures++; $display("FAIL rh_rsp_one_cycle got=%b exp=0", snp_rsp_valid); end
    checks++; if (snp_result !== 2'b01) begin failures++; $display("FAIL rh_result_hold got=%b exp=01", snp_result); end
  endtask
  task automatic test_writeback;
    loc_write(4'd5, 2'b11);
    rd_idx = 4'd5;
    send_snoop(2'b01, 4'd5);
    checks++; if (wb_req !== 1'b0) begin failures++; $display("FAIL wb_req_eval got=%b exp=0", wb_req); end
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++; if (wb_req !== 1'b1) begin failures++; $display("FAIL wb_req_hold c%0d got=%b exp=1", i, wb_req); end
      checks++; if (wb_idx !== 4'd5) begin failures++; $display("FAIL wb_idx_hold c%0d got=%0d exp=5", i, wb_idx); end
      checks++; if (snp_rsp_valid !== 1'b0) begin failures++; $display("FAIL wb_no_rsp c%0d got=%b exp=0", i, snp_rsp_valid); end
      checks++; if (rd_state !== 2'b11) begin failures++; $display("FAIL wb_state_m c%0d got=%b exp=11", i, rd_state); end
      if (i < 3) tick();
    end
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    checks++; if (wb_req !== 1'b0) begin failures++; $display("FAIL wb_drop got=%b exp=0", wb_req); end
    checks++; if (snp_rsp_valid !== 1'b1) begin failures++; $display("FAIL wb_rsp got=%b exp=1", snp_rsp_valid); end
    checks++; if (snp_result !== 2'b10) begin failures++; $display("FAIL wb_hitm got=%b exp=10", snp_result); end
    checks++; if (rd_state !== 2'b00) begin failures++; $display("FAIL wb_state_i got=%b exp=00", rd_state); end
    tick();
  endtask
  task automatic test_read_miss;
    rd_idx = 4'd0;
    send_snoop(2'b00, 4'd0);
    checks++; if (wb_req !== 1'b0) begin failures++; $display("FAIL rm_wb_req got=%b exp=0", wb_req); end
    tick();
    checks++; if (snp_rsp_valid !== 1'b1) begin failures++; $display("FAIL rm_rsp got=%b exp=1", snp_rsp_valid); end
    checks++; if (snp_result !== 2'b00) begin failures++; $display("FAIL rm_nohit got=%b exp=00", snp_result); end
    checks++; if (rd_state !== 2'b00) begin failures++; $display("FAIL rm_state got=%b exp=00", rd_state); end
    checks++; if (wb_req !== 1'b0) begin failures++; $display("FAIL rm_wb_req2 got=%b exp=0", wb_req); end
    tick();
  endtask
  task automatic test_proto_err;
    loc_write(4'd7, 2'b10);
    rd_idx = 4'd7;
    send_snoop(2'b10, 4'd7);
    checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL inv_perr_early got=%b exp=0", proto_err); end
    tick();
    checks++; if (snp_rsp_valid !== 1'b1) begin failures++; $display("FAIL inv_rsp got=%b exp=1", snp_rsp_valid); end
    checks++; if (snp_result !== 2'b01) begin failures++; $display("FAIL inv_hit got=%b exp=01", snp_result); end
    checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL inv_perr got=%b exp=1", proto_err); end
    checks++; if (rd_state !== 2'b00) begin failures++; $display("FAIL inv_state got=%b exp=00", rd_state); end
    tick();
    checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL inv_perr_pulse got=%b exp=0", proto_err); end
    rd_idx = 4'd3;
    send_snoop(2'b11, 4'd3);
    tick();
    checks++; if (snp_rsp_valid !== 1'b1) begin failures++; $display("FAIL wr_rsp got=%b exp=1", snp_rsp_valid); end
    checks++; if (snp_result !== 2'b00) begin failures++; $display("FAIL wr_nohit got=%b exp=00", snp_result); end
    checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL wr_perr got=%b exp=1", proto_err); end
    checks++; if (rd_state !== 2'b01) begin failures++; $display("FAIL wr_state got=%b exp=01", rd_state); end
    tick();
  endtask
  task automatic test_priority;
    rd_idx    = 4'd9;
    snp_valid = 1'b1;
    snp_op    = 2'b00;
    snp_idx   = 4'd3;
    loc_valid = 1'b1;
    loc_idx   = 4'd9;
    loc_state = 2'b11;
    #1;
    checks++; if (snp_ready !== 1'b1) begin failures++; $display("FAIL pr_snp_ready got=%b exp=1", snp_ready); end
    checks++; if (loc_ready !== 1'b0) begin failures++; $display("FAIL pr_loc_ready got=%b exp=0", loc_ready); end
    tick();
    snp_valid = 1'b0;
    checks++; if (loc_ready !== 1'b0) begin failures++; $display("FAIL pr_loc_ready_eval got=%b exp=0", loc_ready); end
    checks++; if (rd_state !== 2'b00) begin failures++; $display("FAIL pr_not_written got=%b exp=00", rd_state); end
    tick();
    checks++; if (snp_rsp_valid !== 1'b1 || snp_result !== 2'b01) begin failures++; $display("FAIL pr_rsp got=%b/%b exp=1/01", snp_rsp_valid, snp_result); end
    checks++; if (loc_ready !== 1'b0) begin failures++; $display("FAIL pr_loc_ready_resp got=%b exp=0", loc_ready); end
    tick();
    checks++; if (loc_ready !== 1'b1) begin failures++; $display("FAIL pr_loc_ready_idle got=%b exp=1", loc_ready); end
    checks++; if (rd_state !== 2'b00) begin failures++; $display("FAIL pr_before_land got=%b exp=00", rd_state); end
    tick();
    loc_valid = 1'b0;
    checks++; if (rd_state !== 2'b11) begin failures++; $display("FAIL pr_landed got=%b exp=11", rd_state); end
  endtask
  task automatic test_reset_mid;
    loc_write(4'd2, 2'b11);
    rd_idx = 4'd2;
    send_snoop(2'b01, 4'd2);
    tick();
    checks++; if (wb_req !== 1'b1) begin failures++; $display("FAIL rm_wb_active got=%b exp=1", wb_req); end
    #2 reset = 1'b1;
    #1;
    checks++; if (wb_req !== 1'b0) begin failures++; $display("FAIL rst_mid_wb_req got=%b exp=0", wb_req); end
    checks++; if (wb_idx !== 4'd0) begin failures++; $display("FAIL rst_mid_wb_idx got=%0d exp=0", wb_idx); end
    checks++; if (rd_state !== 2'b00) begin failures++; $display("FAIL rst_mid_line2 got=%b exp=00", rd_state); end
    rd_idx = 4'd9;
    #1;
    checks++; if (rd_state !== 2'b00) begin failures++; $display("FAIL rst_mid_line9 got=%b exp=00", rd_state); end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (snp_rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_no_rsp c%0d got=%b exp=0", i, snp_rsp_valid); end
    end
    loc_write(4'd4, 2'b10);
    rd_idx = 4'd4;
    send_snoop(2'b00, 4'd4);
    tick();
    checks++; if (snp_rsp_valid !== 1'b1 || snp_result !== 2'b01) begin failures++; $display("FAIL post_rst_rsp got=%b/%b exp=1/01", snp_rsp_valid, snp_result); end
    checks++; if (rd_state !== 2'b01) begin failures++; $display("FAIL post_rst_state got=%b exp=01", rd_state); end
    tick();
  endtask
  initial begin
    test_reset();
    test_read_hit();
    test_writeback();
    test_read_miss();
    test_proto_err();
    test_priority();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
